// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: FSM state encoding and small shared helpers for the
// sequential restoring divider (seq_divider) and its subtract stage.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the iteration counter for an n-bit divide (counts 0..n).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/seq_divider_sub_stage.sv
// seq_divider_sub_stage: W-bit ripple subtractor, Diff = A + ~B + 1, built
// from a chain of full-adder cells. Borrow is the inverted final carry.
module seq_divider_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_carry;
  logic [1:0] w_fa;

  // Ripple A + ~B + 1 through the full-adder chain, LSB first.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    o_diff     = '0;
    w_fa       = 2'b00;
    for (int i = 0; i < W; i++) begin
      w_fa           = full_add(i_a[i], ~i_b[i], w_carry[i]);
      o_diff[i]      = w_fa[0];
      w_carry[i + 1] = w_fa[1];
    end
    o_borrow = ~w_carry[W];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider (DIV/DIVU/REM/REMU).
// One trial subtraction per cycle; Done pulses N+1 cycles after the Start
// edge (one cycle for a zero divisor). Results hold between operations.
// Optional feature macro: SIGNED_DIV_EN enables signed (DIV/REM) semantics;
// without it the i_signed input is ignored and everything is unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);

  localparam int               CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_rem;       // partial remainder
  logic [N-1:0]     r_dq;        // dividend shifts out, quotient shifts in
  logic [N-1:0]     r_div_mag;   // divisor magnitude
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_quot;
  logic [N-1:0]     r_remd;
  logic             r_dbz;

  logic             w_busy_next;
  logic             w_done_next;
  logic             w_start_acc;
  logic             w_divisor_zero;
  logic             w_last;
  logic [N-1:0]     w_dividend_mag;
  logic [N-1:0]     w_divisor_mag;
  logic [N-1:0]     w_quot_final;
  logic [N-1:0]     w_rem_final;
  logic [N:0]       w_trial;
  logic [N:0]       w_diff;
  logic             w_borrow;
  logic             w_unused_diff_msb;

  // Start is only honoured when no operation is in flight.
  assign w_start_acc    = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_divisor_zero = (i_divisor == '0);
  assign w_last         = (r_cnt == CNT_LAST);

`ifdef SIGNED_DIV_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  // Split incoming operands into sign and magnitude.
  always_comb begin
    w_dvd_neg = i_signed & i_dividend[N-1];
    w_dvs_neg = i_signed & i_divisor[N-1];
    if (w_dvd_neg) begin
      w_dividend_mag = ~i_dividend + N'(1);
    end else begin
      w_dividend_mag = i_dividend;
    end
    if (w_dvs_neg) begin
      w_divisor_mag = ~i_divisor + N'(1);
    end else begin
      w_divisor_mag = i_divisor;
    end
  end

  // Remember result signs: quotient negative on differing signs, remainder follows dividend.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start_acc) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end

  // Apply the remembered signs to the unsigned results.
  always_comb begin
    if (r_neg_q) begin
      w_quot_final = ~r_dq + N'(1);
    end else begin
      w_quot_final = r_dq;
    end
    if (r_neg_r) begin
      w_rem_final = ~r_rem + N'(1);
    end else begin
      w_rem_final = r_rem;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_dividend_mag  = i_dividend;
  assign w_divisor_mag   = i_divisor;
  assign w_quot_final    = r_dq;
  assign w_rem_final     = r_rem;
`endif

  // Trial subtraction: shifted partial remainder minus divisor magnitude.
  assign w_trial           = {r_rem, r_dq[N-1]};
  assign w_unused_diff_msb = w_diff[N];

  seq_divider_sub_stage #(
    .W (N + 1)
  ) u_sub_stage (
    .i_a      (w_trial),
    .i_b      ({1'b0, r_div_mag}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero divisor leaves RUN after a single cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_div_zero || w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    w_busy_next = 1'b0;
    w_done_next = 1'b0;
    case (w_state_next)
      ST_RUN:  w_busy_next = 1'b1;
      ST_DONE: w_done_next = 1'b1;
      default: begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
      end
    endcase
  end

  // Registered Busy/Done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  // Operand latch on accepted Start, then one restoring step per RUN cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dq       <= '0;
      r_div_mag  <= '0;
      r_div_zero <= 1'b0;
    end else if (w_start_acc) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      // With a zero divisor no step runs, so keep the raw dividend for the remainder.
      r_dq       <= w_divisor_zero ? i_dividend : w_dividend_mag;
      r_div_mag  <= w_divisor_mag;
      r_div_zero <= w_divisor_zero;
    end else if ((r_state == ST_RUN) && !r_div_zero && !w_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_borrow) begin
        r_rem <= w_trial[N-1:0];
      end else begin
        r_rem <= w_diff[N-1:0];
      end
      r_dq <= {r_dq[N-2:0], ~w_borrow};
    end
  end

  // Results captured only on entry to DONE and held otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else if ((r_state == ST_RUN) && (w_state_next == ST_DONE)) begin
      if (r_div_zero) begin
        r_quot <= {N{1'b1}};
        r_remd <= r_dq;
        r_dbz  <= 1'b1;
      end else begin
        r_quot <= w_quot_final;
        r_remd <= w_rem_final;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_remd;
  assign o_div_by_zero = r_dbz;

endmodule
